// File: rtl/timer_pkg.sv
// Shared field widths, limits, packed layout and opcodes for the multi-channel timer.
// The packed struct bit order matches the display word {hour,min,sec,cs}.
package timer_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int CS_W   = 7;
  localparam int TIME_W = HOUR_W + MIN_W + SEC_W + CS_W;

  localparam int CS_LSB   = 0;
  localparam int SEC_LSB  = CS_LSB + CS_W;
  localparam int MIN_LSB  = SEC_LSB + SEC_W;
  localparam int HOUR_LSB = MIN_LSB + MIN_W;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [CS_W-1:0]   CS_MAX   = 7'd99;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_START   = 3'd1;
  localparam logic [2:0] OP_STOP    = 3'd2;
  localparam logic [2:0] OP_CLEAR   = 3'd3;
  localparam logic [2:0] OP_LOAD    = 3'd4;
  localparam logic [2:0] OP_INC_MIN = 3'd5;
  localparam logic [2:0] OP_DEC_MIN = 3'd6;
  localparam logic [2:0] OP_SET_DIR = 3'd7;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [CS_W-1:0]   cs;
  } time_t;

  // Out-of-range fields saturate at their limit instead of wrapping.
  function automatic time_t clamp_time(input time_t t);
    time_t r;
    r.hour = (t.hour > HOUR_MAX) ? HOUR_MAX : t.hour;
    r.min  = (t.min  > MIN_MAX)  ? MIN_MAX  : t.min;
    r.sec  = (t.sec  > SEC_MAX)  ? SEC_MAX  : t.sec;
    r.cs   = (t.cs   > CS_MAX)   ? CS_MAX   : t.cs;
    return r;
  endfunction

endpackage

// File: rtl/multi_timer_core_channel.sv
// One time channel: hour/min/sec/cs fields, run and direction flags, expiry pulse.
// A tick is dropped when a command other than NOP/START lands on this channel.
module timer_channel
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_i,
  input  logic        cmd_stb_i,
  input  logic [2:0]  op_i,
  input  logic [23:0] cmd_time_i,
  output time_t       time_o,
  output logic        run_o,
  output logic        dir_o,
  output logic        expired_o
);

  time_t time_q, time_d;
  time_t up_t, dn_t;
  logic  run_q, run_d;
  logic  dir_q, dir_d;
  logic  exp_q, exp_d;
  logic  tick_en;

  assign tick_en = tick_i & run_q &
                   (~cmd_stb_i | (op_i == OP_NOP) | (op_i == OP_START));

  always_comb begin
    up_t = time_q;
    if (time_q.cs != CS_MAX) begin
      up_t.cs = time_q.cs + 1'b1;
    end else begin
      up_t.cs = '0;
      if (time_q.sec != SEC_MAX) begin
        up_t.sec = time_q.sec + 1'b1;
      end else begin
        up_t.sec = '0;
        if (time_q.min != MIN_MAX) begin
          up_t.min = time_q.min + 1'b1;
        end else begin
          up_t.min  = '0;
          up_t.hour = (time_q.hour == HOUR_MAX) ? '0 : time_q.hour + 1'b1;
        end
      end
    end
  end

  // Only meaningful for a non-zero value; zero is handled as an expiry.
  always_comb begin
    dn_t = time_q;
    if (time_q.cs != '0) begin
      dn_t.cs = time_q.cs - 1'b1;
    end else begin
      dn_t.cs = CS_MAX;
      if (time_q.sec != '0) begin
        dn_t.sec = time_q.sec - 1'b1;
      end else begin
        dn_t.sec = SEC_MAX;
        if (time_q.min != '0) begin
          dn_t.min = time_q.min - 1'b1;
        end else begin
          dn_t.min  = MIN_MAX;
          dn_t.hour = time_q.hour - 1'b1;
        end
      end
    end
  end

  always_comb begin
    time_d = time_q;
    run_d  = run_q;
    dir_d  = dir_q;
    exp_d  = 1'b0;
    if (tick_en) begin
      if (dir_q) begin
        if ((time_q == '0) || (dn_t == '0)) begin
          time_d = '0;
          run_d  = 1'b0;
          exp_d  = 1'b1;
        end else begin
          time_d = dn_t;
        end
      end else begin
        time_d = up_t;
      end
    end else if (cmd_stb_i) begin
      case (op_i)
        OP_START: run_d = 1'b1;
        OP_STOP:  run_d = 1'b0;
        OP_CLEAR: begin
          time_d = '0;
          run_d  = 1'b0;
        end
        OP_LOAD:  time_d = clamp_time(time_t'(cmd_time_i));
        OP_INC_MIN: begin
          time_d.min = (time_q.min >= MIN_MAX) ? '0 : time_q.min + 1'b1;
          time_d.cs  = '0;
        end
        OP_DEC_MIN: begin
          time_d.min = (time_q.min == '0) ? MIN_MAX : time_q.min - 1'b1;
          time_d.cs  = '0;
        end
        OP_SET_DIR: begin
          dir_d = cmd_time_i[0];
          run_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_q <= '0;
      run_q  <= 1'b0;
      dir_q  <= 1'b0;
      exp_q  <= 1'b0;
    end else begin
      time_q <= time_d;
      run_q  <= run_d;
      dir_q  <= dir_d;
      exp_q  <= exp_d;
    end
  end

  assign time_o    = time_q;
  assign run_o     = run_q;
  assign dir_o     = dir_q;
  assign expired_o = exp_q;

endmodule

// File: rtl/multi_timer_core.sv
// N_CH independent time channels sharing one centisecond prescaler,
// with per-channel command decode and a registered display mux.
module multi_timer_core
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter int N_CH    = 4,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  input  logic [CH_W-1:0] cmd_ch,
  input  logic [2:0]      cmd_op,
  input  logic [23:0]     cmd_time,
  input  logic [CH_W-1:0] disp_sel,
  output logic [23:0]     disp_time,
  output logic [N_CH-1:0] run_vec,
  output logic [N_CH-1:0] dir_vec,
  output logic [N_CH-1:0] expired,
  output logic            tick
);

  localparam int              DIV     = CLK_HZ / TICK_HZ;
  localparam int              PRE_W   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  time_t            ch_time [N_CH];
  logic [23:0]      disp_q, disp_d;

  assign tick  = (pre_q == PRE_MAX);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic cmd_stb;
    assign cmd_stb = cmd_valid && (cmd_ch == CH_W'(g));

    timer_channel u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick_i     (tick),
      .cmd_stb_i  (cmd_stb),
      .op_i       (cmd_op),
      .cmd_time_i (cmd_time),
      .time_o     (ch_time[g]),
      .run_o      (run_vec[g]),
      .dir_o      (dir_vec[g]),
      .expired_o  (expired[g])
    );
  end

  // Loop-compare mux keeps an unpopulated disp_sel value at zero.
  always_comb begin
    disp_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (disp_sel == CH_W'(i)) disp_d = ch_time[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_q <= '0;
    end else begin
      disp_q <= disp_d;
    end
  end

  assign disp_time = disp_q;

endmodule

// File: tb/tb_multi_timer_core.sv
// Randomized and directed checks of multi_timer_core against a time-in-centiseconds model.
module tb_multi_timer_core;

  localparam int DIV = 10;
  localparam int NCH = 4;
  localparam int DAY = 8640000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_ch = '0;
  logic [2:0]  cmd_op = '0;
  logic [23:0] cmd_time = '0;
  logic [1:0]  disp_sel = '0;
  logic [23:0] disp_time;
  logic [3:0]  run_vec, dir_vec, expired;
  logic        tick;

  multi_timer_core #(.CLK_HZ(1000), .TICK_HZ(100), .N_CH(NCH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .cmd_op(cmd_op),
    .cmd_time(cmd_time), .disp_sel(disp_sel), .disp_time(disp_time),
    .run_vec(run_vec), .dir_vec(dir_vec), .expired(expired), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int m_t[NCH];
  bit m_run[NCH], m_dir[NCH], m_exp[NCH];
  int m_pre;
  logic [23:0] m_disp;
  int cur_sel = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pack(input int t);
    logic [4:0] h;
    logic [5:0] m, s;
    logic [6:0] c;
    c = 7'(t % 100);
    s = 6'((t / 100) % 60);
    m = 6'((t / 6000) % 60);
    h = 5'(t / 360000);
    return {h, m, s, c};
  endfunction

  function automatic int load_val(input logic [23:0] p);
    int h, m, s, c;
    h = int'(p[23:19]); m = int'(p[18:13]); s = int'(p[12:7]); c = int'(p[6:0]);
    if (h > 23) h = 23;
    if (m > 59) m = 59;
    if (s > 59) s = 59;
    if (c > 99) c = 99;
    return h * 360000 + m * 6000 + s * 100 + c;
  endfunction

  function automatic int adj_min(input int t, input int delta);
    int h, m, s;
    h = t / 360000; m = (t / 6000) % 60; s = (t / 100) % 60;
    m = (m + delta + 60) % 60;
    return h * 360000 + m * 6000 + s * 100;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_t[c] = 0; m_run[c] = 0; m_dir[c] = 0; m_exp[c] = 0;
    end
    m_pre = 0;
  endtask

  task automatic step(input bit v, input int ch, input int op, input logic [23:0] tm, input int sel);
    bit tk, here, keep;
    logic [3:0] ev_run, ev_dir, ev_exp;
    @(negedge clk);
    cmd_valid = v; cmd_ch = 2'(ch); cmd_op = 3'(op); cmd_time = tm; disp_sel = 2'(sel);
    cur_sel = sel;
    tk = (m_pre == DIV - 1);
    m_disp = pack(m_t[sel]);
    m_pre = tk ? 0 : m_pre + 1;
    for (int c = 0; c < NCH; c++) begin
      m_exp[c] = 0;
      here = v && (ch == c);
      keep = !here || op == 0 || op == 1;
      if (tk && m_run[c] && keep) begin
        if (m_dir[c]) begin
          if (m_t[c] <= 1) begin
            m_t[c] = 0; m_run[c] = 0; m_exp[c] = 1;
          end else begin
            m_t[c] = m_t[c] - 1;
          end
        end else begin
          m_t[c] = (m_t[c] + 1) % DAY;
        end
      end else if (here) begin
        case (op)
          1: m_run[c] = 1;
          2: m_run[c] = 0;
          3: begin m_t[c] = 0; m_run[c] = 0; end
          4: m_t[c] = load_val(tm);
          5: m_t[c] = adj_min(m_t[c], 1);
          6: m_t[c] = adj_min(m_t[c], -1);
          7: begin m_dir[c] = tm[0]; m_run[c] = 0; end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      ev_run[c] = m_run[c]; ev_dir[c] = m_dir[c]; ev_exp[c] = m_exp[c];
    end
    check("tick", 32'(tick), 32'(m_pre == DIV - 1));
    check("run_vec", 32'(run_vec), 32'(ev_run));
    check("dir_vec", 32'(dir_vec), 32'(ev_dir));
    check("expired", 32'(expired), 32'(ev_exp));
    check("disp_time", 32'(disp_time), 32'(m_disp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 24'h0, cur_sel);
  endtask

  initial begin
    int guard, t0, t1, nexp;
    logic [23:0] tm;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_disp", 32'(disp_time), 32'h0);
    check("rst_run", 32'(run_vec), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    @(posedge clk); #2 rst = 1'b1;

    // ch0 counts up for one minute of ticks
    step(1, 0, 1, 24'h0, 0);
    guard = 0;
    while (m_t[0] != 6000 && guard < 70000) begin idle(1); guard++; end
    check("ch0_timeout", 32'(guard < 70000), 32'h1);
    step(1, 0, 2, 24'h0, 0);
    step(0, 0, 0, 24'h0, 0);
    check("ch0_1min", 32'(disp_time), 32'h002000);
    for (int c = 1; c < NCH; c++) begin
      step(0, 0, 0, 24'h0, c);
      step(0, 0, 0, 24'h0, c);
      check("other_ch_zero", 32'(disp_time), 32'h0);
    end

    // day wrap on ch1
    step(1, 1, 4, {5'd23, 6'd59, 6'd59, 7'd99}, 1);
    step(1, 1, 1, 24'h0, 1);
    guard = 0;
    while (m_t[1] != 0 && guard < 20) begin idle(1); guard++; end
    check("wrap_timeout", 32'(guard < 20), 32'h1);
    idle(1);
    check("wrap_value", 32'(disp_time), 32'h0);
    check("wrap_running", 32'(run_vec[1]), 32'h1);

    // ch2 counts down one second and expires once
    step(1, 2, 7, 24'h1, 2);
    step(1, 2, 4, 24'h000080, 2);
    step(1, 2, 1, 24'h0, 2);
    nexp = 0;
    for (int i = 0; i < 1150; i++) begin
      idle(1);
      if (expired[2]) nexp++;
    end
    check("expire_once", 32'(nexp), 32'h1);
    check("expire_value", 32'(disp_time), 32'h0);
    check("expire_stopped", 32'(run_vec[2]), 32'h0);

    // clamping and INC_MIN on ch3
    step(1, 3, 4, {5'd30, 6'd63, 6'd63, 7'd120}, 3);
    step(0, 0, 0, 24'h0, 3);
    check("clamp", 32'(disp_time), 32'({5'd23, 6'd59, 6'd59, 7'd99}));
    step(1, 3, 5, 24'h0, 3);
    step(0, 0, 0, 24'h0, 3);
    check("inc_min", 32'(disp_time), 32'({5'd23, 6'd0, 6'd59, 7'd0}));

    // STOP on ch0 coinciding with a tick
    step(1, 0, 1, 24'h0, 0);
    guard = 0;
    while (m_pre != DIV - 1 && guard < 20) begin idle(1); guard++; end
    t0 = m_t[0]; t1 = m_t[1];
    step(1, 0, 2, 24'h0, 0);
    step(0, 0, 0, 24'h0, 0);
    check("stop_drop_tick", 32'(disp_time), 32'(pack(t0)));
    step(0, 0, 0, 24'h0, 1);
    check("other_ch_ticks", 32'(disp_time), 32'(pack((t1 + 1) % DAY)));

    // asynchronous reset while ch2 counts down
    step(1, 2, 4, 24'h000100, 2);
    step(1, 2, 1, 24'h0, 2);
    idle(53);
    #2 rst = 1'b0;
    #1;
    check("arst_disp", 32'(disp_time), 32'h0);
    check("arst_run", 32'(run_vec), 32'h0);
    check("arst_dir", 32'(dir_vec), 32'h0);
    check("arst_exp", 32'(expired), 32'h0);
    check("arst_tick", 32'(tick), 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    nexp = 0;
    for (int i = 0; i < 300; i++) begin
      idle(1);
      if (expired != 4'h0) nexp++;
    end
    check("no_exp_after_rst", 32'(nexp), 32'h0);
    check("idle_after_rst", 32'(run_vec), 32'h0);
    step(1, 0, 1, 24'h0, 0);
    guard = 0;
    while (m_t[0] != 2 && guard < 40) begin idle(1); guard++; end
    idle(1);
    check("resume", 32'(disp_time), 32'h2);

    // random command traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1)
          tm = {11'h0, 6'($urandom_range(0, 1)), 7'($urandom_range(0, 40))};
        else
          tm = 24'($urandom);
        step(1, $urandom_range(0, NCH - 1), $urandom_range(0, 7), tm, $urandom_range(0, NCH - 1));
      end else begin
        step(0, 0, 0, 24'h0, $urandom_range(0, NCH - 1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
